vdp_port: RTL and testbench

VDP_PORT -- requirements
Module: vdp_port

---
 rtl/vdp_port_if.sv | 30 +++
 rtl/vdp_port.sv | 176 +++++++++++++++++
 tb/tb_vdp_port.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_port_if.sv
// CPU-side and VRAM-side bus of the VDP I/O port, bundled so the port
// block and its environment see matching directions.
`timescale 1ns/1ps
interface vdp_port_if;
  // CPU port (0x98 data, 0x99 control/status)
  logic        cpu_wr;
  logic        cpu_rd;
  logic        cpu_a0;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        busy;
  // VRAM access port
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_wr;
  logic        vram_rd;
  logic [7:0]  vram_rdata;

  // Port block side
  modport slave (
    input  cpu_wr, cpu_rd, cpu_a0, cpu_din, vram_rdata,
    output cpu_dout, busy, vram_addr, vram_wdata, vram_wr, vram_rd
  );

  // CPU / VRAM environment side
  modport master (
    output cpu_wr, cpu_rd, cpu_a0, cpu_din, vram_rdata,
    input  cpu_dout, busy, vram_addr, vram_wdata, vram_wr, vram_rd
  );
endinterface

// File: rtl/vdp_port.sv
// TMS9918-style VDP CPU port: two-byte control latch, register file R0-R7,
// auto-incrementing VRAM address with read-ahead buffer, sticky status.
`timescale 1ns/1ps
module vdp_port (
  input  logic        clk,
  input  logic        reset,
  vdp_port_if.slave   bus,
  output logic [1:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic        video_on,
  output logic        vert_retrace_int,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  input  logic        interrupt_flag,
  input  logic        sprite_collision,
  input  logic        too_many_sprites,
  input  logic [4:0]  sprite5
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_regs [8];
  logic        r_latch;
  logic [7:0]  r_first_byte;
  logic [13:0] r_vaddr;
  logic [7:0]  r_read_buf;
  logic [7:0]  r_cpu_dout;
  logic        r_flag_f;
  logic        r_flag_5s;
  logic        r_flag_c;
  logic [4:0]  r_fifth;

  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_data_wr;
  logic        w_data_rd;
  logic        w_stat_rd;
  logic        w_start_pf;
  logic [4:0]  w_fifth;

  // Strobes are qualified here; anything arriving during a prefetch is dropped.
  assign w_busy     = (r_state != S_IDLE);
  assign w_ctrl_wr  = bus.cpu_wr &  bus.cpu_a0 & ~w_busy;
  assign w_data_wr  = bus.cpu_wr & ~bus.cpu_a0 & ~w_busy;
  assign w_data_rd  = bus.cpu_rd & ~bus.cpu_a0 & ~w_busy;
  assign w_stat_rd  = bus.cpu_rd &  bus.cpu_a0 & ~w_busy;
  assign w_start_pf = w_data_rd |
                      (w_ctrl_wr & r_latch & ~bus.cpu_din[7] & ~bus.cpu_din[6]);
  assign w_fifth    = r_flag_5s ? r_fifth : sprite5;

  // Prefetch FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops sample
    // the same pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Prefetch FSM next state: IDLE -> REQ -> CAP -> IDLE.
  always_comb begin
    // NOTE: default first so no path leaves the variable unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_pf) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs: write pulse is combinational with the CPU strobe,
  // read pulse is the REQ state; they cannot coincide because REQ implies busy.
  always_comb begin
    bus.busy       = w_busy;
    bus.vram_rd    = (r_state == S_REQ);
    bus.vram_wr    = w_data_wr & ~reset;
    bus.vram_addr  = r_vaddr;
    bus.vram_wdata = bus.cpu_din;
    bus.cpu_dout   = r_cpu_dout;
  end

  // CPU access handling: control latch, register file, VRAM address/buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is only eight bytes of flops, so it is reset
      // explicitly; a larger RAM-style array would be left unreset.
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
      r_latch      <= 1'b0;
      r_first_byte <= 8'h00;
      r_vaddr      <= 14'h0000;
      r_read_buf   <= 8'h00;
      r_cpu_dout   <= 8'h00;
    end else begin
      if (r_state == S_CAP) begin
        r_read_buf <= bus.vram_rdata;
        r_vaddr    <= r_vaddr + 14'd1;
      end
      if (w_data_wr) begin
        r_read_buf <= bus.cpu_din;
        r_vaddr    <= r_vaddr + 14'd1;
        r_latch    <= 1'b0;
      end
      if (w_data_rd) begin
        r_cpu_dout <= r_read_buf;
        r_latch    <= 1'b0;
      end
      if (w_stat_rd) begin
        r_cpu_dout <= {r_flag_f, r_flag_5s, r_flag_c, w_fifth};
        r_latch    <= 1'b0;
      end
      if (w_ctrl_wr) begin
        if (!r_latch) begin
          r_first_byte <= bus.cpu_din;
          r_latch      <= 1'b1;
        end else begin
          r_latch <= 1'b0;
          if (bus.cpu_din[7]) r_regs[bus.cpu_din[2:0]] <= r_first_byte;
          else                r_vaddr <= {bus.cpu_din[5:0], r_first_byte};
        end
      end
    end
  end

  // Sticky status flags: a set arriving with the clearing read wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag_f  <= 1'b0;
      r_flag_5s <= 1'b0;
      r_flag_c  <= 1'b0;
      r_fifth   <= 5'd0;
    end else begin
      r_flag_f  <= interrupt_flag   | (r_flag_f  & ~w_stat_rd);
      r_flag_c  <= sprite_collision | (r_flag_c  & ~w_stat_rd);
      r_flag_5s <= too_many_sprites | (r_flag_5s & ~w_stat_rd);
      if (too_many_sprites && (!r_flag_5s || w_stat_rd)) r_fifth <= sprite5;
    end
  end

  // Register decode: pure combinational view of R0-R7.
  always_comb begin
    video_on         = r_regs[1][6];
    vert_retrace_int = r_regs[1][5];
    sprite_large     = r_regs[1][1];
    sprite_enlarged  = r_regs[1][0];
    text_color       = r_regs[7][7:4];
    back_color       = r_regs[7][3:0];

    if      (r_regs[1][4]) mode = 2'd0;
    else if (r_regs[0][1]) mode = 2'd2;
    else if (r_regs[1][3]) mode = 2'd3;
    else                   mode = 2'd1;

    name_table_addr           = {r_regs[2][3:0], 10'b0};
    sprite_attr_addr          = {r_regs[5][6:0], 7'b0};
    sprite_pattern_table_addr = {r_regs[6][2:0], 11'b0};

    if (mode == 2'd2) begin
      color_table_addr = {r_regs[3][7], 13'b0};
      font_addr        = {r_regs[4][2], 13'b0};
    end else begin
      color_table_addr = {r_regs[3], 6'b0};
      font_addr        = {r_regs[4][2:0], 11'b0};
    end
  end

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port: stimulus pushes expected VRAM pulses and CPU
// read data into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vdp_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vdp_port_if vif();

  logic [1:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [3:0]  text_color, back_color;
  logic        interrupt_flag, sprite_collision, too_many_sprites;
  logic [4:0]  sprite5;

  vdp_port dut (
    .clk                       (clk),
    .reset                     (reset),
    .bus                       (vif.slave),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .text_color                (text_color),
    .back_color                (back_color),
    .interrupt_flag            (interrupt_flag),
    .sprite_collision          (sprite_collision),
    .too_many_sprites          (too_many_sprites),
    .sprite5                   (sprite5)
  );

  // VRAM model: read data valid the cycle after vram_rd.
  logic [7:0] mem [16384];
  always @(posedge clk) begin
    if (vif.vram_wr) mem[vif.vram_addr] <= vif.vram_wdata;
    if (vif.vram_rd) vif.vram_rdata <= mem[vif.vram_addr];
  end

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [13:0] exp_rd_q[$];
  logic [7:0]  exp_dout_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every VRAM pulse and the cpu_dout following a read.
  logic rd_seen = 1'b0;
  always @(negedge clk) begin
    if (vif.vram_wr && vif.vram_rd) check("wr_rd_overlap", 1, 0);
    if (vif.vram_wr) begin
      if (exp_wr_q.size() == 0) check("unexpected_vram_wr", {18'd0, vif.vram_addr}, 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("vram_wr_addr", {18'd0, vif.vram_addr}, {18'd0, e.addr});
        check("vram_wdata",   {24'd0, vif.vram_wdata}, {24'd0, e.data});
      end
    end
    if (vif.vram_rd) begin
      if (exp_rd_q.size() == 0) check("unexpected_vram_rd", {18'd0, vif.vram_addr}, 32'hFFFF_FFFF);
      else check("vram_rd_addr", {18'd0, vif.vram_addr}, {18'd0, exp_rd_q.pop_front()});
    end
    if (rd_seen) begin
      if (exp_dout_q.size() == 0) check("unexpected_read", {24'd0, vif.cpu_dout}, 32'hFFFF_FFFF);
      else check("cpu_dout", {24'd0, vif.cpu_dout}, {24'd0, exp_dout_q.pop_front()});
    end
    rd_seen = vif.cpu_rd && !vif.busy && !reset;
  end

  // One CPU strobe cycle followed by idle cycles to cover a prefetch.
  task automatic op(input logic wr, input logic rd, input logic a0,
                    input logic [7:0] din, input logic irq);
    @(posedge clk); #1;
    vif.cpu_wr = wr; vif.cpu_rd = rd; vif.cpu_a0 = a0; vif.cpu_din = din;
    interrupt_flag = irq;
    @(posedge clk); #1;
    vif.cpu_wr = 1'b0; vif.cpu_rd = 1'b0; interrupt_flag = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic ctrl(input logic [7:0] d);
    op(1'b1, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic ctrl_pf(input logic [7:0] d, input logic [13:0] rd_addr);
    exp_rd_q.push_back(rd_addr);
    op(1'b1, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic reg_wr(input logic [2:0] idx, input logic [7:0] val);
    ctrl(val);
    ctrl({5'b10000, idx});
  endtask

  task automatic dwr(input logic [13:0] addr, input logic [7:0] d);
    wr_t e;
    e.addr = addr; e.data = d;
    exp_wr_q.push_back(e);
    op(1'b1, 1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic drd(input logic [7:0] dout, input logic [13:0] rd_addr);
    exp_dout_q.push_back(dout);
    exp_rd_q.push_back(rd_addr);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic srd(input logic [7:0] dout, input logic irq);
    exp_dout_q.push_back(dout);
    op(1'b0, 1'b1, 1'b1, 8'h00, irq);
  endtask

  task automatic pulse(input logic irq, input logic col, input logic tms);
    @(posedge clk); #1;
    interrupt_flag = irq; sprite_collision = col; too_many_sprites = tms;
    @(posedge clk); #1;
    interrupt_flag = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    reset = 1'b1;
    vif.cpu_wr = 1'b0; vif.cpu_rd = 1'b0; vif.cpu_a0 = 1'b0; vif.cpu_din = 8'h00;
    interrupt_flag = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0;
    sprite5 = 5'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_mode",     {30'd0, mode}, 32'd1);
    check("rst_name",     {18'd0, name_table_addr}, 32'd0);
    check("rst_color",    {18'd0, color_table_addr}, 32'd0);
    check("rst_font",     {18'd0, font_addr}, 32'd0);
    check("rst_video_on", {31'd0, video_on}, 32'd0);
    check("rst_vert_int", {31'd0, vert_retrace_int}, 32'd0);
    check("rst_busy",     {31'd0, vif.busy}, 32'd0);
    check("rst_dout",     {24'd0, vif.cpu_dout}, 32'd0);

    // Register write to R7
    reg_wr(3'd7, 8'hF4);
    check("text_color", {28'd0, text_color}, 32'hF);
    check("back_color", {28'd0, back_color}, 32'h4);

    // VRAM writes with auto-increment (also shows the latch was cleared)
    ctrl(8'h00); ctrl(8'h40);
    dwr(14'h0000, 8'hAA);
    dwr(14'h0001, 8'h55);

    // Preload 0x12 at 0x1234, then read-ahead
    ctrl(8'h34); ctrl(8'h52);
    dwr(14'h1234, 8'h12);
    ctrl(8'h34); ctrl_pf(8'h12, 14'h1234);
    drd(8'h12, 14'h1235);

    // Address wrap 0x3FFF -> 0x0000
    ctrl(8'hFF); ctrl(8'h7F);
    dwr(14'h3FFF, 8'h01);
    dwr(14'h0000, 8'h02);

    // Sticky status F and C
    sprite5 = 5'h03;
    pulse(1'b1, 1'b1, 1'b0);
    srd(8'hA3, 1'b0);
    srd(8'h03, 1'b0);
    srd(8'h03, 1'b1);   // set coincides with clear: pre-set value read
    srd(8'h83, 1'b0);   // F survived the clear

    // 5S latches the sprite number at the overflow cycle
    sprite5 = 5'h0A;
    pulse(1'b0, 1'b0, 1'b1);
    sprite5 = 5'h11;
    srd(8'h4A, 1'b0);
    srd(8'h11, 1'b0);

    // Mode and table bases
    reg_wr(3'd1, 8'h00); reg_wr(3'd0, 8'h02); reg_wr(3'd4, 8'h07); reg_wr(3'd3, 8'hFF);
    check("g2_mode",  {30'd0, mode}, 32'd2);
    check("g2_font",  {18'd0, font_addr}, 32'h2000);
    check("g2_color", {18'd0, color_table_addr}, 32'h2000);
    reg_wr(3'd1, 8'h10);
    check("txt_mode",  {30'd0, mode}, 32'd0);
    check("txt_color", {18'd0, color_table_addr}, 32'h3FC0);
    check("txt_font",  {18'd0, font_addr}, 32'h3800);
    reg_wr(3'd0, 8'h00); reg_wr(3'd1, 8'h08);
    check("mc_mode", {30'd0, mode}, 32'd3);
    reg_wr(3'd1, 8'h62);
    check("g1_mode",      {30'd0, mode}, 32'd1);
    check("video_on",     {31'd0, video_on}, 32'd1);
    check("vert_int",     {31'd0, vert_retrace_int}, 32'd1);
    check("sprite_large", {31'd0, sprite_large}, 32'd1);
    check("sprite_enl",   {31'd0, sprite_enlarged}, 32'd0);
    reg_wr(3'd2, 8'h0F); reg_wr(3'd5, 8'h7F); reg_wr(3'd6, 8'h07);
    check("name_addr",   {18'd0, name_table_addr}, 32'h3C00);
    check("spr_attr",    {18'd0, sprite_attr_addr}, 32'h3F80);
    check("spr_pattern", {18'd0, sprite_pattern_table_addr}, 32'h3800);

    // Reset during REQ aborts the prefetch; read_buf stays 0
    ctrl(8'h34);
    exp_rd_q.push_back(14'h1234);
    @(posedge clk); #1;
    vif.cpu_wr = 1'b1; vif.cpu_a0 = 1'b1; vif.cpu_din = 8'h12;
    @(posedge clk); #1;
    vif.cpu_wr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_mode", {30'd0, mode}, 32'd1);
    check("post_rst_busy", {31'd0, vif.busy}, 32'd0);
    drd(8'h00, 14'h0000);
    drd(8'h02, 14'h0001);

    repeat (5) @(posedge clk);
    check("wr_q_empty",   exp_wr_q.size(), 0);
    check("rd_q_empty",   exp_rd_q.size(), 0);
    check("dout_q_empty", exp_dout_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
